// File: rtl/counter_updown_bcd.sv
// counter_updown_bcd: prescaled modulo-(MAX_COUNT+1) up/down counter with a lockstep BCD copy
module counter_updown_bcd #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MAX_COUNT = 9999,
  parameter int DIGITS = 4,
  localparam int CW = $clog2(MAX_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic                  i_mode,
  output logic [CW-1:0]         o_count,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_tick,
  output logic                  o_wrap
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  localparam logic [PW-1:0] LAST_P = PW'(DIV - 1);

  // shift-and-add-3 conversion, evaluated only at elaboration
  function automatic logic [4*DIGITS-1:0] bcd_of(input logic [CW-1:0] v);
    logic [4*DIGITS-1:0] b;
    b = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++)
        if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
      b = {b[4*DIGITS-2:0], v[i]};
    end
    return b;
  endfunction

  localparam logic [4*DIGITS-1:0] BCD_MAX = bcd_of(MAX_C);

  logic [PW-1:0]       psc_q, psc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_step;
  logic                tick_q, tick_d, wrap_q, wrap_d;
  logic                step, wrap_c, carry, at_edge;
  logic [3:0]          dig;

  assign step   = i_run & ~i_clear & (psc_q == LAST_P);
  assign wrap_c = i_mode ? (count_q == '0) : (count_q == MAX_C);

  // per-digit ripple: carry on 9->0 going up, borrow on 0->9 going down
  always_comb begin
    carry = 1'b1;
    dig = '0;
    at_edge = 1'b0;
    bcd_step = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = bcd_q[4*d +: 4];
      at_edge = i_mode ? (dig == 4'd0) : (dig == 4'd9);
      bcd_step[4*d +: 4] = !carry ? dig : at_edge ? (i_mode ? 4'd9 : 4'd0) : (i_mode ? dig - 4'd1 : dig + 4'd1);
      carry = carry & at_edge;
    end
  end

  assign psc_d   = (i_clear || step) ? '0 : i_run ? psc_q + PW'(1) : psc_q;
  assign count_d = i_clear ? '0 : !step ? count_q : wrap_c ? (i_mode ? MAX_C : '0)
                 : i_mode ? count_q - CW'(1) : count_q + CW'(1);
  assign bcd_d   = i_clear ? '0 : !step ? bcd_q : wrap_c ? (i_mode ? BCD_MAX : '0) : bcd_step;
  assign tick_d  = step;
  assign wrap_d  = step & wrap_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q   <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count = count_q;
  assign o_bcd   = bcd_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;
endmodule

// File: tb/tb_counter_updown_bcd.sv
// tb_counter_updown_bcd: directed vector table, corner sequences and a randomized run against an arithmetic model
module tb_counter_updown_bcd;
  localparam int DIV = 10;
  localparam int MAXC = 9999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_run = 1'b0, i_clear = 1'b0, i_mode = 1'b0;
  logic [13:0] o_count;
  logic [15:0] o_bcd;
  logic        o_tick, o_wrap;

  int checks = 0, failures = 0;
  int m_cnt = 0, m_ph = 0, m_tick = 0, m_wrap = 0;

  counter_updown_bcd #(.CLK_FREQ(100), .TICK_HZ(10), .MAX_COUNT(MAXC), .DIGITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_clear(i_clear), .i_mode(i_mode),
    .o_count(o_count), .o_bcd(o_bcd), .o_tick(o_tick), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic run, clr, mode;
    int   n;
    int   cnt;
    logic [15:0] bcd;
    logic tick, wrap;
  } vec_t;
  vec_t vecs[20];

  function automatic int bcd_ref(input int v);
    int r = 0, p = 1;
    for (int d = 0; d < 4; d++) begin
      r |= ((v / p) % 10) << (4 * d);
      p *= 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_cnt = 0; m_ph = 0; m_tick = 0; m_wrap = 0;
    end else if (i_clear) begin
      m_cnt = 0; m_ph = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_tick = 0; m_wrap = 0;
      if (i_run) begin
        m_ph++;
        if (m_ph == DIV) begin
          m_ph = 0;
          m_tick = 1;
          if (i_mode) begin
            m_cnt = (m_cnt + MAXC) % (MAXC + 1);
            m_wrap = int'(m_cnt == MAXC);
          end else begin
            m_cnt = (m_cnt + 1) % (MAXC + 1);
            m_wrap = int'(m_cnt == 0);
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model_count", int'(o_count), m_cnt);
      check("model_bcd", int'(o_bcd), bcd_ref(m_cnt));
      check("model_tick", int'(o_tick), m_tick);
      check("model_wrap", int'(o_wrap), m_wrap);
    end
  endtask

  task automatic check_out(input string name, input int cnt, input int bcd, input int tick, input int wrap);
    check({name, "_count"}, int'(o_count), cnt);
    check({name, "_bcd"}, int'(o_bcd), bcd);
    check({name, "_tick"}, int'(o_tick), tick);
    check({name, "_wrap"}, int'(o_wrap), wrap);
  endtask

  initial begin
    int k;
    vecs[0]  = '{1, 0, 0, 9,   0,    16'h0000, 0, 0};
    vecs[1]  = '{1, 0, 0, 1,   1,    16'h0001, 1, 0};
    vecs[2]  = '{1, 0, 0, 1,   1,    16'h0001, 0, 0};
    vecs[3]  = '{1, 0, 0, 979, 99,   16'h0099, 1, 0};
    vecs[4]  = '{1, 0, 0, 10,  100,  16'h0100, 1, 0};
    vecs[5]  = '{1, 0, 1, 10,  99,   16'h0099, 1, 0};
    vecs[6]  = '{0, 1, 1, 1,   0,    16'h0000, 0, 0};
    vecs[7]  = '{1, 0, 1, 10,  9999, 16'h9999, 1, 1};
    vecs[8]  = '{1, 0, 1, 1,   9999, 16'h9999, 0, 0};
    vecs[9]  = '{1, 0, 0, 9,   0,    16'h0000, 1, 1};
    vecs[10] = '{1, 0, 0, 5,   0,    16'h0000, 0, 0};
    vecs[11] = '{0, 0, 0, 50,  0,    16'h0000, 0, 0};
    vecs[12] = '{1, 0, 0, 4,   0,    16'h0000, 0, 0};
    vecs[13] = '{1, 0, 0, 1,   1,    16'h0001, 1, 0};
    vecs[14] = '{0, 1, 0, 1,   0,    16'h0000, 0, 0};
    vecs[15] = '{1, 0, 0, 420, 42,   16'h0042, 1, 0};
    vecs[16] = '{1, 0, 0, 9,   42,   16'h0042, 0, 0};
    vecs[17] = '{1, 1, 0, 1,   0,    16'h0000, 0, 0};
    vecs[18] = '{1, 0, 0, 9,   0,    16'h0000, 0, 0};
    vecs[19] = '{1, 0, 0, 1,   1,    16'h0001, 1, 0};

    repeat (3) @(negedge clk);
    check_out("reset", 0, 0, 0, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 20; v++) begin
      i_run = vecs[v].run; i_clear = vecs[v].clr; i_mode = vecs[v].mode;
      cyc(vecs[v].n);
      check_out($sformatf("vec%0d", v), vecs[v].cnt, int'(vecs[v].bcd), int'(vecs[v].tick), int'(vecs[v].wrap));
    end

    // count up to 1234, then pulse reset between edges
    i_run = 1'b0; i_clear = 1'b1; i_mode = 1'b0;
    cyc(1);
    i_run = 1'b1; i_clear = 1'b0;
    cyc(12340);
    check_out("pre_reset", 1234, 16'h1234, 1, 0);
    #2 reset_n = 1'b0;
    #1 check_out("async_reset", 0, 0, 0, 0);
    m_cnt = 0; m_ph = 0; m_tick = 0; m_wrap = 0;
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      cyc(1);
      if (o_tick) k = i;
    end
    check("recover_tick_edge", k, DIV);
    check("recover_count", int'(o_count), 1);

    for (int i = 0; i < 25000; i++) begin
      i_run = ($urandom_range(0, 9) != 0);
      i_clear = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0) i_mode = ~i_mode;
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
